// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage IF/ID/EX/MEM/WB core.
// Tracks in-flight destination registers and stalls decode on a read-after-write
// hazard. It also sequences a fixed-length flush after a taken branch and keeps
// saturating stall/flush event counters.
module hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter bit          WB_BYPASS    = 1'b0,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             RN,
    input  logic [31:0]      id_ir,
    input  logic             id_valid,
    input  logic             br_taken,
    output logic             pc_hold,
    output logic             ex_bubble,
    output logic             flush_if_id,
    output logic             flushing,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
    } tag_t;

    localparam logic [6:0]       TYPE_AR   = 7'd0;
    localparam logic [6:0]       TYPE_M    = 7'd1;
    localparam logic [6:0]       TYPE_BR   = 7'd2;
    localparam logic [6:0]       TYPE_SH   = 7'd3;
    localparam logic [2:0]       FCNT_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // A tag matches a source only when it is valid and the source is not r0.
    function automatic logic tag_hit(input tag_t t, input logic [4:0] r);
        return t.v && (r != 5'd0) && (t.rd == r);
    endfunction

    state_t     state_r, state_nxt_s;
    logic [2:0] fcnt_r, fcnt_nxt_s;
    tag_t       ex_tag_r, mem_tag_r, wb_tag_r, id_tag_s;

    logic [6:0] op_s;
    logic [2:0] funct3_s;
    logic [4:0] rd_s, rs1_s, rs2_s;
    logic       use_rs1_s, use_rs2_s, use_rd_s, writes_s;
    logic       hit_rs1_s, hit_rs2_s, hit_rd_s;
    logic       hazard_s;

    assign op_s     = id_ir[6:0];
    assign funct3_s = id_ir[14:12];
    assign rd_s     = id_ir[11:7];
    assign rs1_s    = id_ir[19:15];
    assign rs2_s    = id_ir[24:20];

    // Decode which register fields the ID instruction reads and whether it writes rd.
    always_comb begin
        use_rs1_s = 1'b0;
        use_rs2_s = 1'b0;
        use_rd_s  = 1'b0;
        writes_s  = 1'b0;
        case (op_s)
            TYPE_AR: begin
                writes_s  = 1'b1;
                use_rs1_s = 1'b1;
                use_rs2_s = (id_ir[31:25] == 7'd1);
            end
            TYPE_M: begin
                case (funct3_s)
                    3'd0: begin
                        writes_s  = 1'b1;
                        use_rs1_s = 1'b1;
                    end
                    3'd1: begin
                        use_rs1_s = 1'b1;
                        use_rs2_s = 1'b1;
                        use_rd_s  = 1'b1;
                    end
                    default: begin
                        writes_s = 1'b0;
                    end
                endcase
            end
            TYPE_BR: begin
                use_rs1_s = 1'b1;
                use_rd_s  = 1'b1;
            end
            TYPE_SH: begin
                writes_s  = 1'b1;
                use_rs1_s = 1'b1;
                use_rs2_s = 1'b1;
            end
            default: begin
                writes_s = 1'b0;
            end
        endcase
    end

    // Compare each used source against the in-flight window (WB optionally bypassed).
    always_comb begin
        hit_rs1_s = tag_hit(ex_tag_r, rs1_s) || tag_hit(mem_tag_r, rs1_s)
                    || (!WB_BYPASS && tag_hit(wb_tag_r, rs1_s));
        hit_rs2_s = tag_hit(ex_tag_r, rs2_s) || tag_hit(mem_tag_r, rs2_s)
                    || (!WB_BYPASS && tag_hit(wb_tag_r, rs2_s));
        hit_rd_s  = tag_hit(ex_tag_r, rd_s) || tag_hit(mem_tag_r, rd_s)
                    || (!WB_BYPASS && tag_hit(wb_tag_r, rd_s));
        // A taken branch squashes the ID instruction, so it must not hold the PC.
        hazard_s  = id_valid && (state_r == ST_RUN) && !br_taken
                    && ((use_rs1_s && hit_rs1_s) || (use_rs2_s && hit_rs2_s)
                        || (use_rd_s && hit_rd_s));
        id_tag_s.v  = id_valid && !ex_bubble && writes_s && (rd_s != 5'd0);
        id_tag_s.rd = rd_s;
    end

    assign flushing    = (state_r == ST_FLUSH);
    assign pc_hold     = hazard_s;
    assign flush_if_id = br_taken || flushing;
    assign ex_bubble   = hazard_s || br_taken || flushing;

    // Flush sequencer next state: a branch (re)loads the hold count, otherwise count down.
    always_comb begin
        state_nxt_s = state_r;
        fcnt_nxt_s  = fcnt_r;
        case (state_r)
            ST_RUN: begin
                if (br_taken) begin
                    state_nxt_s = ST_FLUSH;
                    fcnt_nxt_s  = FCNT_LOAD;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (br_taken) begin
                    fcnt_nxt_s = FCNT_LOAD;
                end else if (fcnt_r == 3'd0) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    fcnt_nxt_s = fcnt_r - 3'd1;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
                fcnt_nxt_s  = 3'd0;
            end
        endcase
    end

    // Flush sequencer state register.
    always_ff @(posedge clk) begin
        if (RN) begin
            state_r <= ST_RUN;
            fcnt_r  <= 3'd0;
        end else begin
            state_r <= state_nxt_s;
            fcnt_r  <= fcnt_nxt_s;
        end
    end

    // Destination-tag pipeline; tags keep draining through flushes.
    always_ff @(posedge clk) begin
        if (RN) begin
            ex_tag_r  <= '0;
            mem_tag_r <= '0;
            wb_tag_r  <= '0;
        end else begin
            ex_tag_r  <= id_tag_s;
            mem_tag_r <= ex_tag_r;
            wb_tag_r  <= mem_tag_r;
        end
    end

    // Saturating debug counters for stall cycles and taken-branch events.
    always_ff @(posedge clk) begin
        if (RN) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (pc_hold && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (br_taken && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl. Two instances share the stimulus:
// u_dut0 uses the defaults (WB compared, 16-bit counters); u_dut1 bypasses WB
// and has 2-bit counters so that saturation is reachable.
// Expected outputs come from a hand-written table that is queued at drive time.
module tb_hazard_ctrl;

    logic        clk;
    logic        RN;
    logic [31:0] id_ir;
    logic        id_valid;
    logic        br_taken;

    logic        ph0, eb0, fi0, fl0;
    logic [15:0] sc0, fc0;
    logic        ph1, eb1, fi1, fl1;
    logic [1:0]  sc1, fc1;

    int total = 0;
    int bad   = 0;
    int step_no = 0;
    logic [4:0] exp_q[$];

    hazard_ctrl #(.FLUSH_CYCLES(2), .WB_BYPASS(1'b0), .CNT_W(16)) u_dut0 (
        .clk(clk), .RN(RN), .id_ir(id_ir), .id_valid(id_valid), .br_taken(br_taken),
        .pc_hold(ph0), .ex_bubble(eb0), .flush_if_id(fi0), .flushing(fl0),
        .stall_cnt(sc0), .flush_cnt(fc0)
    );

    hazard_ctrl #(.FLUSH_CYCLES(2), .WB_BYPASS(1'b1), .CNT_W(2)) u_dut1 (
        .clk(clk), .RN(RN), .id_ir(id_ir), .id_valid(id_valid), .br_taken(br_taken),
        .pc_hold(ph1), .ex_bubble(eb1), .flush_if_id(fi1), .flushing(fl1),
        .stall_cnt(sc1), .flush_cnt(fc1)
    );

    // Free-running core clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guard against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog step=%0d", step_no);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%0d want=%0d", tag, step_no, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3,
                                       input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    // One cycle: drive inputs, queue expectation {ph,eb,fi,fl} of dut0 plus pc_hold of dut1,
    // compare at the falling edge, then advance past the rising edge.
    task automatic step(input logic [31:0] ir, input logic v, input logic br,
                        input logic [3:0] e0, input logic e1_ph);
        logic [4:0] e;
        step_no++;
        id_ir    = ir;
        id_valid = v;
        br_taken = br;
        exp_q.push_back({e0, e1_ph});
        @(negedge clk);
        e = exp_q.pop_front();
        chk("pc_hold",       {31'd0, ph0}, {31'd0, e[4]});
        chk("ex_bubble",     {31'd0, eb0}, {31'd0, e[3]});
        chk("flush_if_id",   {31'd0, fi0}, {31'd0, e[2]});
        chk("flushing",      {31'd0, fl0}, {31'd0, e[1]});
        chk("byp_pc_hold",   {31'd0, ph1}, {31'd0, e[0]});
        chk("byp_ex_bubble", {31'd0, eb1}, {31'd0, e[0] | e[2]});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(32'h0000_007F, 1'b0, 1'b0, 4'b0000, 1'b0);
    endtask

    task automatic chk_cnt(input int s0, input int f0, input int s1, input int f1);
        chk("stall_cnt",     {16'd0, sc0}, s0);
        chk("flush_cnt",     {16'd0, fc0}, f0);
        chk("byp_stall_cnt", {30'd0, sc1}, s1);
        chk("byp_flush_cnt", {30'd0, fc1}, f1);
    endtask

    logic [31:0] add6, sub7, and8, add9, lw13, sw13, lw0, nop;

    initial begin
        add6 = mk(7'd1, 5'd2, 5'd1,  3'd0, 5'd6,  7'd0);
        sub7 = mk(7'd1, 5'd2, 5'd1,  3'd1, 5'd7,  7'd0);
        and8 = mk(7'd1, 5'd3, 5'd1,  3'd7, 5'd8,  7'd0);
        add9 = mk(7'd1, 5'd2, 5'd6,  3'd0, 5'd9,  7'd0);
        lw13 = mk(7'd0, 5'd2, 5'd1,  3'd0, 5'd13, 7'd1);
        sw13 = mk(7'd0, 5'd3, 5'd13, 3'd1, 5'd2,  7'd1);
        lw0  = mk(7'd0, 5'd2, 5'd1,  3'd0, 5'd0,  7'd1);
        nop  = 32'h0000_007F;

        RN = 1'b1; id_ir = 32'd0; id_valid = 1'b0; br_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1 RN = 1'b0;
        @(negedge clk);
        chk("rst_pc_hold",     {31'd0, ph0}, 32'd0);
        chk("rst_ex_bubble",   {31'd0, eb0}, 32'd0);
        chk("rst_flush_if_id", {31'd0, fi0}, 32'd0);
        chk("rst_flushing",    {31'd0, fl0}, 32'd0);
        chk_cnt(0, 0, 0, 0);
        @(posedge clk);
        #1;

        // Independent stream: no stalls.
        step(add6, 1'b1, 1'b0, 4'b0000, 1'b0);
        step(sub7, 1'b1, 1'b0, 4'b0000, 1'b0);
        step(and8, 1'b1, 1'b0, 4'b0000, 1'b0);
        chk_cnt(0, 0, 0, 0);
        idle(3);

        // Adjacent RAW: 3-cycle stall with WB compared, 2 with WB bypassed.
        step(add6, 1'b1, 1'b0, 4'b0000, 1'b0);
        step(add9, 1'b1, 1'b0, 4'b1100, 1'b1);
        step(add9, 1'b1, 1'b0, 4'b1100, 1'b1);
        step(add9, 1'b1, 1'b0, 4'b1100, 1'b0);
        step(add9, 1'b1, 1'b0, 4'b0000, 1'b0);
        chk_cnt(3, 0, 2, 0);
        idle(3);

        // Load then store two slots later: hazard only against the WB tag.
        step(lw13, 1'b1, 1'b0, 4'b0000, 1'b0);
        step(nop,  1'b1, 1'b0, 4'b0000, 1'b0);
        step(nop,  1'b1, 1'b0, 4'b0000, 1'b0);
        step(sw13, 1'b1, 1'b0, 4'b1100, 1'b0);
        step(sw13, 1'b1, 1'b0, 4'b0000, 1'b0);
        chk_cnt(4, 0, 2, 0);
        // Same with writer rd=0: never a hazard.
        step(lw0,  1'b1, 1'b0, 4'b0000, 1'b0);
        step(nop,  1'b1, 1'b0, 4'b0000, 1'b0);
        step(nop,  1'b1, 1'b0, 4'b0000, 1'b0);
        step(sw13, 1'b1, 1'b0, 4'b0000, 1'b0);
        chk_cnt(4, 0, 2, 0);

        // Taken branch over a hazarding ID instruction: flush wins.
        step(add6, 1'b1, 1'b0, 4'b0000, 1'b0);
        step(add9, 1'b1, 1'b1, 4'b0110, 1'b0);
        step(add9, 1'b1, 1'b0, 4'b0111, 1'b0);
        step(add9, 1'b1, 1'b0, 4'b0111, 1'b0);
        step(add9, 1'b1, 1'b0, 4'b0000, 1'b0);
        chk_cnt(4, 1, 2, 1);
        idle(3);

        // Second branch one cycle into the flush extends it.
        step(nop, 1'b0, 1'b1, 4'b0110, 1'b0);
        step(nop, 1'b0, 1'b1, 4'b0111, 1'b0);
        step(nop, 1'b0, 1'b0, 4'b0111, 1'b0);
        step(nop, 1'b0, 1'b0, 4'b0111, 1'b0);
        step(nop, 1'b0, 1'b0, 4'b0000, 1'b0);
        chk_cnt(4, 3, 2, 3);
        // One more branch: the 2-bit flush counter holds at all-ones.
        step(nop, 1'b0, 1'b1, 4'b0110, 1'b0);
        step(nop, 1'b0, 1'b0, 4'b0111, 1'b0);
        step(nop, 1'b0, 1'b0, 4'b0111, 1'b0);
        step(nop, 1'b0, 1'b0, 4'b0000, 1'b0);
        chk_cnt(4, 4, 2, 3);

        // Reset mid-stall with valid tags; 2-bit stall counter saturates first.
        step(add6, 1'b1, 1'b0, 4'b0000, 1'b0);
        step(add9, 1'b1, 1'b0, 4'b1100, 1'b1);
        step(add9, 1'b1, 1'b0, 4'b1100, 1'b1);
        chk_cnt(6, 4, 3, 3);
        RN = 1'b1;
        step(nop,  1'b0, 1'b0, 4'b0000, 1'b0);
        RN = 1'b0;
        step(add9, 1'b1, 1'b0, 4'b0000, 1'b0);
        chk_cnt(0, 0, 0, 0);

        // Reset mid-flush returns to RUN.
        step(nop, 1'b0, 1'b1, 4'b0110, 1'b0);
        RN = 1'b1;
        step(nop, 1'b0, 1'b0, 4'b0111, 1'b0);
        RN = 1'b0;
        step(nop, 1'b0, 1'b0, 4'b0000, 1'b0);
        chk_cnt(0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage IF/ID/EX/MEM/WB core.
- Keeps a scoreboard of in-flight destination registers and holds fetch/decode (stall) while the ID-stage instruction reads a register that an older instruction has not yet written back.
- On a taken branch reported by EX, sequences a fixed-length flush of the younger stages.
- Keeps saturating stall and flush event counters for debug.

Parameters:
- FLUSH_CYCLES, 2, number of cycles the flush is held after a taken branch (1..7).
- WB_BYPASS, 0, when 1 the WB-stage tag is excluded from hazard compare (register file write-before-read); when 0 it is included.
- CNT_W, 16, width of the stall/flush event counters.

Ports:
- clk  input  1  core clock, all state on posedge
- RN  input  1  reset; synchronous, active-high
- id_ir  input  32  instruction currently held in IF/ID
- id_valid  input  1  IF/ID holds a real instruction
- br_taken  input  1  one-cycle pulse from EX: branch resolved taken
- pc_hold  output  1  hold NPC and IF/ID this cycle
- ex_bubble  output  1  load a NOP (IR=32'h0000007F, non-writing) into ID/EX this cycle
- flush_if_id  output  1  invalidate IF/ID contents
- flushing  output  1  FSM in FLUSH state
- stall_cnt  output  CNT_W  cycles with pc_hold=1, saturating
- flush_cnt  output  CNT_W  taken-branch flush events, saturating

Behaviour:
- Decode fields:
  - type = IR[6:0]: AR=0, M=1, BR=2, SH=3.
  - funct3 = IR[14:12]; rd = IR[11:7]; rs1 = IR[19:15]; rs2 = IR[24:20].
- Writers (set a tag): AR, SH, M with funct3=0 (LW). Destination is rd.
- Sources read by each type:
  - AR with IR[31:25]=1: rs1, rs2.
  - AR otherwise: rs1.
  - SH: rs1, rs2.
  - LW: rs1.
  - SW (M, funct3=1): rs1, rs2, rd.
  - BR: rs1, rd.
  - Any other type: no sources, no write.
- Register 0 never causes a hazard and never sets a valid tag.
- Scoreboard: three registered tags {v, rd} for ex_tag, mem_tag, wb_tag.
  - Every cycle: wb_tag <= mem_tag; mem_tag <= ex_tag.
  - ex_tag <= writer tag of id_ir if id_valid & ~ex_bubble, else invalid.
- hazard (combinational): id_valid & FSM=RUN & any used source equals the rd of a valid ex_tag or mem_tag, or of wb_tag when WB_BYPASS=0.
- FSM has two states, RUN and FLUSH, and a 3-bit counter fcnt.
  - RUN -> FLUSH on br_taken; fcnt <= FLUSH_CYCLES-1.
  - In FLUSH: decrement fcnt; return to RUN when fcnt=0 and no br_taken.
  - br_taken while in FLUSH restarts fcnt at FLUSH_CYCLES-1 and increments flush_cnt again.
- Outputs:
  - pc_hold = hazard.
  - flush_if_id = br_taken | flushing.
  - ex_bubble = hazard | br_taken | flushing.
  - flushing = (state==FLUSH).
- Simultaneous events:
  - br_taken with hazard: flush wins; pc_hold=0 so NPC may load the branch target; the ID instruction is squashed.
  - Older tags keep draining during a flush; they are never cleared by a branch.
- Latency:
  - A dependent instruction in ID stalls 3 cycles behind an adjacent writer (2 cycles if WB_BYPASS=1).
  - It is released in the cycle after the matching tag leaves the compared window.
- Counters:
  - stall_cnt += 1 each cycle pc_hold=1.
  - flush_cnt += 1 each cycle br_taken=1.
  - Both hold at all-ones.
- Reset (RN=1 at posedge, including mid-flush or mid-stall):
  - state=RUN, fcnt=0, all tags invalid, stall_cnt=0, flush_cnt=0.
  - Hence pc_hold=0, ex_bubble=0, flush_if_id=0, flushing=0 in the cycle after reset (br_taken low).

Test Plan:
- Independent stream add r6,r1,r2; sub r7,r1,r2; and r8,r1,r3 -> pc_hold stays 0, stall_cnt=0, ex_tag rd sequence 6,7,8.
- add r6,r1,r2 then add r9,r6,r2, WB_BYPASS=0 -> pc_hold=1 for exactly 3 cycles, 3 bubbles, stall_cnt=3; WB_BYPASS=1 -> 2 cycles.
- lw r13,r1,2 followed two slots later by sw r3,r13,2 (r13 in rs1) -> stall 1 cycle (WB_BYPASS=0); same with writer rd=0 -> no stall.
- br_taken pulse while ID holds a hazarding instruction -> pc_hold=0 that cycle, flushing=1 for 2 cycles, ex_bubble=1 for 3 cycles, flush_cnt=1.
- Second br_taken one cycle into FLUSH -> FLUSH extended to end 2 cycles after the second pulse, flush_cnt=2.
- Assert RN mid-stall with valid tags -> next cycle all outputs 0, counters 0; a dependent instruction presented immediately does not stall.
